// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU request arbiter: slot states, width/command
// encodings and tag sizing.
package lsu_pkg;

   localparam int NUM_SLOTS = 4;
   localparam int TAG_W     = 2;
   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 16;

   typedef enum logic [1:0] {
      SLOT_FREE   = 2'd0,
      SLOT_PEND   = 2'd1,
      SLOT_ISSUED = 2'd2
   } slot_state_t;

   localparam logic WIDTH_16 = 1'b0;
   localparam logic WIDTH_8  = 1'b1;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/rr_pick4.sv
// Four-way grant picker: round-robin from a pointer, or fixed priority with
// slot 0 highest when RR_EN is 0. Purely combinational.
module rr_pick4
   import lsu_pkg::*;
#(
   parameter int RR_EN = 1
) (
   input  logic [3:0]       pend,
   input  logic [TAG_W-1:0] ptr,
   output logic [3:0]       gnt,
   output logic [TAG_W-1:0] idx,
   output logic             any
);

   logic [TAG_W-1:0] base;
   logic [TAG_W-1:0] cand;
   logic             found;

   // scan pending slots starting at the base, wrapping 3->0 through the 2-bit add
   always_comb begin
      gnt   = '0;
      idx   = '0;
      any   = |pend;
      found = 1'b0;
      cand  = '0;
      base  = (RR_EN != 0) ? ptr : '0;
      for (int k = 0; k < 4; k++) begin
         cand = base + TAG_W'(k);
         if (!found && pend[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/lsu_rq_arbiter.sv
// Four-slot request buffer in front of the LSU. Stations post requests into
// their own slot; one pending slot is granted per cycle and issued unless the
// LSU holds. Reads wait in ISSUED for a completion notice, writes free at issue.
module lsu_rq_arbiter
   import lsu_pkg::*;
#(
   parameter int RR_EN = 1
) (
   input  logic                        clk,
   input  logic                        a_rst,
   input  logic [NUM_SLOTS-1:0]        st_valid,
   input  logic [NUM_SLOTS*ADDR_W-1:0] st_addr,
   input  logic [NUM_SLOTS*DATA_W-1:0] st_data,
   input  logic [NUM_SLOTS-1:0]        st_width,
   input  logic [NUM_SLOTS-1:0]        st_cmd,
   output logic [NUM_SLOTS-1:0]        st_ready,
   input  logic                        flush,
   output logic [ADDR_W-1:0]           rq_addr,
   output logic [DATA_W-1:0]           rq_data,
   output logic                        rq_width,
   output logic                        rq_cmd,
   output logic [TAG_W-1:0]            rq_tag,
   output logic                        rq_start,
   input  logic                        rq_hold,
   input  logic                        rs_wb,
   input  logic [TAG_W-1:0]            rs_tag
);

   slot_state_t          state [NUM_SLOTS];
   logic [TAG_W-1:0]     ptr;
   logic [ADDR_W-1:0]    addr_q [NUM_SLOTS];
   logic [DATA_W-1:0]    data_q [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] width_q;
   logic [NUM_SLOTS-1:0] cmd_q;
   logic [NUM_SLOTS-1:0] pend;
   logic [NUM_SLOTS-1:0] cap;
   logic [NUM_SLOTS-1:0] gnt;
   logic [TAG_W-1:0]     gnt_idx;
   logic                 any_pend;
   logic                 issue;

   // decode registered slot state; flush blocks any capture that cycle
   always_comb begin
      pend     = '0;
      st_ready = '0;
      cap      = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         pend[i]     = (state[i] == SLOT_PEND);
         st_ready[i] = (state[i] == SLOT_FREE);
         cap[i]      = st_valid[i] & st_ready[i] & ~flush;
      end
   end

   rr_pick4 #(.RR_EN(RR_EN)) u_pick (
      .pend (pend),
      .ptr  (ptr),
      .gnt  (gnt),
      .idx  (gnt_idx),
      .any  (any_pend)
   );

   assign issue = any_pend & ~rq_hold;

   // per-slot state machines plus the round-robin pointer
   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) state[i] <= SLOT_FREE;
         ptr <= '0;
      end else begin
         if (issue) ptr <= gnt_idx + TAG_W'(1);
         for (int i = 0; i < NUM_SLOTS; i++) begin
            case (state[i])
               SLOT_FREE:
                  if (cap[i]) state[i] <= SLOT_PEND;
               SLOT_PEND:
                  // an issuing slot ignores a concurrent flush
                  if (issue && gnt[i])
                     state[i] <= (cmd_q[i] == CMD_WR) ? SLOT_FREE : SLOT_ISSUED;
                  else if (flush)
                     state[i] <= SLOT_FREE;
               SLOT_ISSUED:
                  if (rs_wb && rs_tag == TAG_W'(i)) state[i] <= SLOT_FREE;
               default:
                  state[i] <= SLOT_FREE;
            endcase
         end
      end
   end

   // payload registers load on capture only; contents are don't-care while FREE
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (cap[i]) begin
            addr_q[i]  <= st_addr[ADDR_W*i +: ADDR_W];
            data_q[i]  <= st_data[DATA_W*i +: DATA_W];
            width_q[i] <= st_width[i];
            cmd_q[i]   <= st_cmd[i];
         end
      end
   end

   // request to the LSU from the granted slot, zero when nothing is pending
   always_comb begin
      rq_start = any_pend;
      rq_addr  = '0;
      rq_data  = '0;
      rq_width = 1'b0;
      rq_cmd   = 1'b0;
      rq_tag   = '0;
      if (any_pend) begin
         rq_addr  = addr_q[gnt_idx];
         rq_data  = data_q[gnt_idx];
         rq_width = width_q[gnt_idx];
         rq_cmd   = cmd_q[gnt_idx];
         rq_tag   = gnt_idx;
      end
   end

endmodule
